dmem_ctrl: RTL and testbench

Requester-side controller for the single-port synchronous `ram` used as data memory. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake. It converts byte addresses to word addresses. Loads are sign- or zero-extended. Sub-word stores are done as a read-modify-write, because the RAM has only a whole-word write enable. It sits between the core's memory stage and the data `ram` instance, and owns every RAM port.

---
 rtl/dmem_pkg.sv | 82 ++++++++
 rtl/dmem_align.sv | 40 ++++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory controller.
//   mem_size_e    - request size encoding (matches the core's 2-bit size field)
//   dmem_state_e  - controller FSM states
//   lane_replicate(wdata, size)             - copy right-aligned store data into every lane
//   load_extend(word, offset, size, is_unsigned) - select a lane and sign/zero-extend it
//   store_merge(old, new_data, offset, size)     - replace the target lane(s) of old
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW,
        ST_WACK,
        ST_ERR
    } dmem_state_e;

    localparam int LANE_BYTES = 4;

    // With the data copied into every lane, the merge only needs a lane mask,
    // not a variable shift of the store data.
    function automatic logic [31:0] lane_replicate(input logic [31:0] wdata,
                                                   input mem_size_e   size);
        logic [31:0] result;
        case (size)
            BYTE:    result = {LANE_BYTES{wdata[7:0]}};
            HALF:    result = {2{wdata[15:0]}};
            default: result = wdata;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input mem_size_e   size,
                                                input logic        is_unsigned);
        logic        [31:0] shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        logic        [31:0] result;
        // Little-endian: offset 0 is bits [7:0]; halves are aligned so only offset[1] matters.
        shifted = word >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        ext_s   = '0;
        case (size)
            BYTE: begin
                ext_s  = byte_s;
                result = is_unsigned ? {24'd0, shifted[7:0]} : ext_s;
            end
            HALF: begin
                ext_s  = half_s;
                result = is_unsigned ? {16'd0, shifted[15:0]} : ext_s;
            end
            WORD:    result = word;
            default: result = '0;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] new_data,
                                                input logic [1:0]  offset,
                                                input mem_size_e   size);
        logic [31:0] mask;
        case (size)
            BYTE:    mask = 32'h0000_00FF << {offset, 3'b000};
            HALF:    mask = 32'h0000_FFFF << {offset[1], 4'b0000};
            WORD:    mask = '1;
            default: mask = '0;
        endcase
        return (old & ~mask) | (new_data & mask);
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane logic for dmem_ctrl.
//   req_offset/req_size/req_wdata - live request fields (misalignment check, replication)
//   ram_rdata                     - word read back from the RAM
//   lat_offset/lat_size/lat_unsigned/lat_wdata - fields latched at accept
//   misaligned  - request is misaligned or has the illegal size
//   wdata_repl  - store data copied into every lane, ready to latch
//   load_data   - extended load result
//   merge_data  - read word with the target lane(s) replaced
import dmem_pkg::*;

module dmem_align (
    input  logic [1:0]  req_offset,
    input  mem_size_e   req_size,
    input  logic [31:0] req_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [1:0]  lat_offset,
    input  mem_size_e   lat_size,
    input  logic        lat_unsigned,
    input  logic [31:0] lat_wdata,
    output logic        misaligned,
    output logic [31:0] wdata_repl,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            HALF:    misaligned = req_offset[0];
            WORD:    misaligned = (req_offset != 2'b00);
            ILLEGAL: misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign wdata_repl = lane_replicate(req_wdata, req_size);
    assign load_data  = load_extend(ram_rdata, lat_offset, lat_size, lat_unsigned);
    assign merge_data = store_merge(ram_rdata, lat_wdata, lat_offset, lat_size);

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: requester-side controller for the single-port data RAM.
//   i_clk, i_rst_n               - clock, async active-low reset
//   i_req_valid/o_req_ready      - request handshake (ready only in IDLE)
//   i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata - request fields
//   o_rsp_valid, o_rsp_rdata, o_rsp_err - one-cycle response
//   o_ram_we, o_ram_addr, o_ram_wrdata, i_ram_rdata - RAM port (rdata one cycle after addr)
// Word stores write in the accept cycle; sub-word stores read in the accept
// cycle and write the merged word in the following RMW cycle.
import dmem_pkg::*;

module dmem_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [31:0]           i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wrdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    dmem_state_e           state_q, state_d;
    mem_size_e             req_size;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] req_word_addr;
    logic                  misaligned;
    logic [31:0]           wdata_repl;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;

    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [1:0]            off_p1;
    mem_size_e             size_p1;
    logic                  uns_p1;
    logic [31:0]           wdata_p1;

    // Bits above the RAM word address are dropped, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_req_addr[31:ADDR_WIDTH+2];

    assign req_size      = mem_size_e'(i_req_size);
    assign req_word_addr = i_req_addr[ADDR_WIDTH+1:2];
    assign o_req_ready   = (state_q == ST_IDLE);
    assign accept        = i_req_valid & (state_q == ST_IDLE);

    dmem_align u_align (
        .req_offset   (i_req_addr[1:0]),
        .req_size     (req_size),
        .req_wdata    (i_req_wdata),
        .ram_rdata    (i_ram_rdata),
        .lat_offset   (off_p1),
        .lat_size     (size_p1),
        .lat_unsigned (uns_p1),
        .lat_wdata    (wdata_p1),
        .misaligned   (misaligned),
        .wdata_repl   (wdata_repl),
        .load_data    (load_data),
        .merge_data   (merge_data)
    );

    // Stage p1: state and request fields captured at accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            addr_p1  <= '0;
            off_p1   <= '0;
            size_p1  <= BYTE;
            uns_p1   <= 1'b0;
            wdata_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_p1  <= req_word_addr;
                off_p1   <= i_req_addr[1:0];
                size_p1  <= req_size;
                uns_p1   <= i_req_unsigned;
                wdata_p1 <= wdata_repl;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        o_rsp_valid  = 1'b0;
        o_rsp_err    = 1'b0;
        o_rsp_rdata  = '0;
        o_ram_we     = 1'b0;
        o_ram_addr   = addr_p1;
        o_ram_wrdata = '0;
        case (state_q)
            ST_IDLE: begin
                // Address goes straight to the RAM so a load or RMW read
                // returns its data in the next cycle.
                o_ram_addr   = req_word_addr;
                o_ram_wrdata = i_req_wdata;
                if (accept) begin
                    if (misaligned) begin
                        state_d = ST_ERR;
                    end else if (!i_req_we) begin
                        state_d = ST_RD;
                    end else if (req_size == WORD) begin
                        // Gated by reset so a request held during reset never writes.
                        o_ram_we = i_rst_n;
                        state_d  = ST_WACK;
                    end else begin
                        state_d = ST_RMW;
                    end
                end
            end
            ST_RD: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = load_data;
                state_d     = ST_IDLE;
            end
            ST_RMW: begin
                o_ram_we     = 1'b1;
                o_ram_wrdata = merge_data;
                state_d      = ST_WACK;
            end
            ST_WACK: begin
                o_rsp_valid = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a behavioural 4K x 32
// synchronous RAM (read-before-write, one cycle read latency).
module tb_dmem_ctrl;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wrdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    int          checks   = 0;
    int          failures = 0;
    logic        we_acc;
    int          rsp_lat;
    int          we_cnt;
    logic [31:0] got_data;
    logic        got_err;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wrdata;
        ram_rdata <= mem[ram_addr];
    end

    dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_addr     (req_addr),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_ram_we       (ram_we),
        .o_ram_addr     (ram_addr),
        .o_ram_wrdata   (ram_wrdata),
        .i_ram_rdata    (ram_rdata)
    );

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = size; req_unsigned = uns; req_wdata = wd;
        @(negedge clk);
        we_acc = ram_we;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response; latency counted from the accept edge.
    task automatic wait_rsp();
        rsp_lat = 0; we_cnt = 0; got_data = '0; got_err = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
            if (rsp_valid) begin
                rsp_lat = i; got_data = rsp_rdata; got_err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word();
        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF);
        wait_rsp();
        checks++; if (we_acc !== 1'b1) begin failures++; $display("FAIL wst_we_accept got=%b exp=1", we_acc); end
        checks++; if (we_cnt != 0) begin failures++; $display("FAIL wst_we_after got=%0d exp=0", we_cnt); end
        checks++; if (rsp_lat != 1) begin failures++; $display("FAIL wst_latency got=%0d exp=1", rsp_lat); end
        checks++; if (got_err !== 1'b0 || got_data !== 32'h0) begin failures++; $display("FAIL wst_rsp got=%h/%b exp=0/0", got_data, got_err); end
        checks++; if (mem[12'h040] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[12'h040]); end
        issue(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        req_addr = 32'h0000_0FFC;
        @(negedge clk);
        checks++; if (ram_addr !== 12'h040) begin failures++; $display("FAIL wld_addr_hold got=%h exp=040", ram_addr); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            failures++; $display("FAIL wld_rsp got=%b/%h/%b exp=1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (we_acc !== 1'b0) begin failures++; $display("FAIL wld_we got=%b exp=0", we_acc); end
    endtask

    task automatic test_byte_store();
        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'h1122_3344);
        wait_rsp();
        issue(1'b1, 32'h102, 2'b00, 1'b0, 32'h0000_00AA);
        wait_rsp();
        checks++; if (we_acc !== 1'b0) begin failures++; $display("FAIL bst_we_accept got=%b exp=0", we_acc); end
        checks++; if (rsp_lat != 2) begin failures++; $display("FAIL bst_latency got=%0d exp=2", rsp_lat); end
        checks++; if (we_cnt != 1) begin failures++; $display("FAIL bst_we_count got=%0d exp=1", we_cnt); end
        checks++; if (got_err !== 1'b0) begin failures++; $display("FAIL bst_err got=%b exp=0", got_err); end
        issue(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        wait_rsp();
        checks++; if (got_data !== 32'h11AA_3344) begin failures++; $display("FAIL bst_readback got=%h exp=11aa3344", got_data); end
    endtask

    task automatic test_load_ext();
        logic [31:0] exp_tab [6];
        logic [31:0] addr_tab [6];
        logic [1:0]  size_tab [6];
        logic        uns_tab [6];
        addr_tab = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h102};
        size_tab = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        uns_tab  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_tab  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_007F, 32'hFFFF_FFFF};
        issue(1'b1, 32'h100, 2'b10, 1'b0, 32'h80FF_7F01);
        wait_rsp();
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, addr_tab[i], size_tab[i], uns_tab[i], 32'h0);
            wait_rsp();
            checks++;
            if (rsp_lat != 1 || got_data !== exp_tab[i] || got_err !== 1'b0) begin
                failures++;
                $display("FAIL load_ext[%0d] got=%h lat=%0d err=%b exp=%h lat=1 err=0", i, got_data, rsp_lat, got_err, exp_tab[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addr_tab [3];
        logic [1:0]  size_tab [3];
        logic        we_tab [3];
        addr_tab = '{32'h101, 32'h102, 32'h100};
        size_tab = '{2'b01, 2'b10, 2'b11};
        we_tab   = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue(we_tab[i], addr_tab[i], size_tab[i], 1'b0, 32'hBEEF_BEEF);
            wait_rsp();
            checks++;
            if (rsp_lat != 1 || got_err !== 1'b1 || got_data !== 32'h0 || we_acc !== 1'b0 || we_cnt != 0) begin
                failures++;
                $display("FAIL err_req[%0d] lat=%0d err=%b data=%h we=%b/%0d exp lat=1 err=1 data=0 we=0/0",
                         i, rsp_lat, got_err, got_data, we_acc, we_cnt);
            end
        end
        checks++; if (mem[12'h040] !== 32'h80FF_7F01) begin failures++; $display("FAIL err_mem got=%h exp=80ff7f01", mem[12'h040]); end
    endtask

    task automatic test_wrap();
        issue(1'b1, 32'h4000_0104, 2'b10, 1'b0, 32'h0000_0005);
        wait_rsp();
        issue(1'b0, 32'h104, 2'b10, 1'b0, 32'h0);
        wait_rsp();
        checks++; if (got_data !== 32'h0000_0005) begin failures++; $display("FAIL wrap_load got=%h exp=00000005", got_data); end
        issue(1'b1, 32'h106, 2'b01, 1'b0, 32'h0000_CAFE);
        wait_rsp();
        checks++; if (rsp_lat != 2) begin failures++; $display("FAIL hst_latency got=%0d exp=2", rsp_lat); end
        checks++; if (mem[12'h041] !== 32'hCAFE_0005) begin failures++; $display("FAIL hst_mem got=%h exp=cafe0005", mem[12'h041]); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int rsp = 0;
        int wes = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h104; req_size = 2'b10; req_unsigned = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ram_we) wes++;
            checks++;
            if (req_ready !== ((i % 2) == 0)) begin
                failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, req_ready, (i % 2) == 0);
            end
            if (req_ready) acc++;
            if (rsp_valid) begin
                rsp++;
                checks++;
                if (rsp_rdata !== 32'hCAFE_0005) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=cafe0005", i, rsp_rdata); end
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (acc != 4 || rsp != 4 || wes != 0) begin
            failures++; $display("FAIL b2b_counts acc=%0d rsp=%0d we=%0d exp=4/4/0", acc, rsp, wes); end
        @(negedge clk);
    endtask

    task automatic test_reset_rmw();
        issue(1'b1, 32'h200, 2'b10, 1'b0, 32'h1234_5678);
        wait_rsp();
        issue(1'b1, 32'h200, 2'b00, 1'b0, 32'h0000_00AA);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL rmw_we got=%b exp=1", ram_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rmw_abort we=%b rsp=%b exp=0/0", ram_we, rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmw_no_rsp got=%b exp=0", rsp_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rmw_release ready=%b rsp=%b exp=1/0", req_ready, rsp_valid); end
        checks++; if (mem[12'h080] !== 32'h1234_5678) begin failures++; $display("FAIL rmw_mem got=%h exp=12345678", mem[12'h080]); end
        issue(1'b0, 32'h200, 2'b10, 1'b0, 32'h0);
        wait_rsp();
        checks++; if (got_data !== 32'h1234_5678) begin failures++; $display("FAIL rmw_readback got=%h exp=12345678", got_data); end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
        we_acc = 1'b0; rsp_lat = 0; we_cnt = 0; got_data = '0; got_err = 1'b0;
        test_reset();
        test_word();
        test_byte_store();
        test_load_ext();
        test_errors();
        test_wrap();
        test_back_to_back();
        test_reset_rmw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
